// File: rtl/rx_frame_controller.sv
// UART receive frame controller: start/data/parity/stop sequencing driven
// by a 16x oversampling baud tick; emits one word per frame with error flags.
//
// Ports:
//   clk, rx_arst_n (async, active-low), rx_rst (sync, active-high)
//   rx_en          receiver enable, low aborts the frame and forces IDLE
//   rx             synchronized serial line, idle high
//   baud_tick      one-cycle pulse at OS_RATE x baud
//   cfg_parity_en  parity bit present; cfg_parity_odd selects odd parity
//   data_out       last received word (LSB received first)
//   data_valid     one-cycle pulse when data_out and error flags update
//   parity_err     parity mismatch on the last frame
//   frame_err      stop bit sampled low on the last frame
//   busy           high whenever not IDLE
module rx_frame_controller #(
    parameter int DATA_BITS = 8,
    parameter int OS_RATE   = 16
) (
    input  logic                 clk,
    input  logic                 rx_arst_n,
    input  logic                 rx_rst,
    input  logic                 rx_en,
    input  logic                 rx,
    input  logic                 baud_tick,
    input  logic                 cfg_parity_en,
    input  logic                 cfg_parity_odd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int OSW = $clog2(OS_RATE);
    localparam int BCW = $clog2(DATA_BITS);

    localparam logic [OSW-1:0] OS_HALF  = OSW'(OS_RATE / 2 - 1);
    localparam logic [OSW-1:0] OS_LAST  = OSW'(OS_RATE - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]           state;
    logic [OSW-1:0]       os_cnt;
    logic [BCW-1:0]       bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_en;
    logic                 par_odd;
    logic                 par_bad;

    logic os_last_tick;
    assign os_last_tick = baud_tick && (os_cnt == OS_LAST);

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rx_arst_n) begin
        if (!rx_arst_n) begin
            state      <= S_IDLE;
            os_cnt     <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            par_en     <= 1'b0;
            par_odd    <= 1'b0;
            par_bad    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (rx_rst) begin
                state      <= S_IDLE;
                os_cnt     <= '0;
                bit_cnt    <= '0;
                shift      <= '0;
                par_en     <= 1'b0;
                par_odd    <= 1'b0;
                par_bad    <= 1'b0;
                data_out   <= '0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end else if (!rx_en) begin
                // abort: outputs hold, no data_valid
                state  <= S_IDLE;
                os_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        os_cnt <= '0;
                        if (!rx) begin
                            state   <= S_START;
                            par_en  <= cfg_parity_en;
                            par_odd <= cfg_parity_odd;
                        end
                    end
                    S_START: begin
                        if (baud_tick) begin
                            if (os_cnt == OS_HALF) begin
                                os_cnt  <= '0;
                                bit_cnt <= '0;
                                // high at mid-start means a glitch
                                state   <= rx ? S_IDLE : S_DATA;
                            end else begin
                                os_cnt <= os_cnt + 1'b1;
                            end
                        end
                    end
                    S_DATA: begin
                        if (os_last_tick) begin
                            os_cnt  <= '0;
                            shift   <= {rx, shift[DATA_BITS-1:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == BIT_LAST) begin
                                state <= par_en ? S_PARITY : S_STOP;
                            end
                        end else if (baud_tick) begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                    S_PARITY: begin
                        if (os_last_tick) begin
                            os_cnt  <= '0;
                            // total ones odd is bad for even parity
                            par_bad <= (^shift) ^ rx ^ par_odd;
                            state   <= S_STOP;
                        end else if (baud_tick) begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (os_last_tick) begin
                            os_cnt     <= '0;
                            frame_err  <= ~rx;
                            parity_err <= par_en & par_bad;
                            data_out   <= shift;
                            data_valid <= 1'b1;
                            state      <= S_IDLE;
                        end else if (baud_tick) begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state  <= S_IDLE;
                        os_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_frame_controller.sv
// Self-checking bench for rx_frame_controller: directed and random frames
// against a behavioural frame model.
module tb_rx_frame_controller;

    localparam int DB  = 8;
    localparam int BIT = 64;

    logic          clk;
    logic          rx_arst_n;
    logic          rx_rst;
    logic          rx_en;
    logic          rx;
    logic          baud_tick;
    logic          cfg_parity_en;
    logic          cfg_parity_odd;
    logic [DB-1:0] data_out;
    logic          data_valid;
    logic          parity_err;
    logic          frame_err;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int vld_cnt = 0;
    int busy_drop = 0;
    bit watch = 0;
    int tcnt = 0;

    rx_frame_controller #(.DATA_BITS(DB), .OS_RATE(16)) dut (
        .clk           (clk),
        .rx_arst_n     (rx_arst_n),
        .rx_rst        (rx_rst),
        .rx_en         (rx_en),
        .rx            (rx),
        .baud_tick     (baud_tick),
        .cfg_parity_en (cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .parity_err    (parity_err),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // baud tick every 4 clk
    initial baud_tick = 1'b0;
    always @(negedge clk) begin
        tcnt = tcnt + 1;
        baud_tick = (tcnt % 4 == 0);
    end

    always @(negedge clk) begin
        if (data_valid) begin
            vld_cnt = vld_cnt + 1;
            watch = 0;
        end else if (watch && !busy) begin
            busy_drop = busy_drop + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic pen,
                              input logic podd, input logic pbit,
                              input logic sbit);
        cfg_parity_en  = pen;
        cfg_parity_odd = podd;
        rx = 1'b0;
        @(negedge clk);
        watch = 1;
        // config changes mid-frame must be ignored
        cfg_parity_en  = 1'($urandom);
        cfg_parity_odd = 1'($urandom);
        repeat (BIT - 1) @(negedge clk);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
        if (pen) send_bit(pbit);
        if (sbit) begin
            send_bit(1'b1);
        end else begin
            // short low stop: past the sample point, then idle
            rx = 1'b0;
            repeat (40) @(negedge clk);
            rx = 1'b1;
        end
        watch = 0;
        repeat (2 * BIT) @(negedge clk);
    endtask

    task automatic partial(input logic [DB-1:0] d, input int n);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < n; i++) send_bit(d[i]);
    endtask

    task automatic frame_chk(input string tag, input logic [DB-1:0] d,
                             input logic pen, input logic podd,
                             input logic pbit, input logic sbit);
        int  v0;
        int  ones;
        logic odd_total;
        logic exp_perr;
        v0 = vld_cnt;
        send_frame(d, pen, podd, pbit, sbit);
        ones = $countones(d) + (pen ? int'(pbit) : 0);
        odd_total = (ones % 2) == 1;
        exp_perr = pen && (odd_total != podd);
        chk({tag, ".vld"}, vld_cnt - v0, 1);
        chk({tag, ".data"}, 32'(data_out), 32'(d));
        chk({tag, ".perr"}, 32'(parity_err), 32'(exp_perr));
        chk({tag, ".ferr"}, 32'(frame_err), 32'(!sbit));
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, ".data"}, 32'(data_out), 0);
        chk({tag, ".perr"}, 32'(parity_err), 0);
        chk({tag, ".ferr"}, 32'(frame_err), 0);
        chk({tag, ".vld"}, 32'(data_valid), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
    endtask

    initial begin
        int v0;
        logic [DB-1:0] d0;
        logic [DB-1:0] rd;
        logic rpen, rpodd, rpbit, rsbit;

        rx = 1'b1;
        rx_en = 1'b1;
        rx_rst = 1'b0;
        rx_arst_n = 1'b0;
        cfg_parity_en = 1'b0;
        cfg_parity_odd = 1'b0;
        repeat (3) @(negedge clk);
        zero_chk("reset");
        rx_arst_n = 1'b1;
        repeat (10) @(negedge clk);

        busy_drop = 0;
        frame_chk("a5_8n1", 8'hA5, 0, 0, 0, 1);
        chk("a5_busy", busy_drop, 0);

        frame_chk("03_even", 8'h03, 1, 0, 0, 1);
        frame_chk("03_odd", 8'h03, 1, 1, 0, 1);

        frame_chk("55_stop0", 8'h55, 0, 0, 0, 0);
        frame_chk("0f_clean", 8'h0F, 0, 0, 0, 1);

        // 3-tick glitch
        v0 = vld_cnt;
        d0 = data_out;
        rx = 1'b0;
        repeat (12) @(negedge clk);
        rx = 1'b1;
        chk("glitch.busy_hi", 32'(busy), 1);
        repeat (60) @(negedge clk);
        chk("glitch.busy_lo", 32'(busy), 0);
        chk("glitch.vld", vld_cnt - v0, 0);
        chk("glitch.data", 32'(data_out), 32'(d0));

        // abort via rx_en in data bit 4
        v0 = vld_cnt;
        partial(8'h3C, 4);
        rx = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        rx_en = 1'b0;
        @(negedge clk);
        chk("abort.busy", 32'(busy), 0);
        repeat (4 * BIT) @(negedge clk);
        chk("abort.vld", vld_cnt - v0, 0);
        chk("abort.data", 32'(data_out), 32'(d0));
        rx_en = 1'b1;
        repeat (4) @(negedge clk);
        frame_chk("81_after", 8'h81, 0, 0, 0, 1);

        // async reset mid-frame
        partial(8'h5A, 3);
        rx_arst_n = 1'b0;
        #1;
        zero_chk("arst");
        rx = 1'b1;
        @(negedge clk);
        rx_arst_n = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        frame_chk("3c_post_arst", 8'h3C, 1, 0, 0, 1);

        // sync reset mid-frame
        partial(8'h99, 5);
        rx_rst = 1'b1;
        @(negedge clk);
        zero_chk("srst");
        rx_rst = 1'b0;
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        frame_chk("e7_post_srst", 8'hE7, 1, 1, 1, 1);

        for (int i = 0; i < 20; i++) begin
            rd    = DB'($urandom);
            rpen  = 1'($urandom);
            rpodd = 1'($urandom);
            rpbit = 1'($urandom);
            rsbit = ($urandom % 4) != 0;
            frame_chk($sformatf("rnd%0d", i), rd, rpen, rpodd, rpbit,
                      rsbit);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
